// File: rtl/mux_pkg.sv
// Shared constants and select helpers for the mux_pipe_n selector family.
package mux_pkg;

    localparam int unsigned MUX_MAX_IN = 16;

    // True when a binary select addresses one of the n real inputs.
    function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned n);
        return sel < n;
    endfunction

endpackage

// File: rtl/mux_pipe_n_if.sv
// Valid/ready bus for mux_pipe_n: upstream beat (data, select) and downstream registered beat.
interface mux_pipe_n_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3
);
    localparam int unsigned SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_sel_err;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel_err, out_valid
    );

endinterface

// File: rtl/mux_pipe_stage.sv
// Single valid register slice holding one beat; flush beats load, load beats clear.
module mux_pipe_stage #(
    parameter int unsigned DW = 33
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          load_i,
    input  logic          clr_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mux_pipe_n.sv
// N-way registered selector with valid/ready handshake and saturating bad-select counter.
// Define MUX_SKID_EN to add a skid entry and make in_ready purely registered.
module mux_pipe_n
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    mux_pipe_n_if.slave      bus,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned SEL_W = $clog2(NUM_IN);

    if (NUM_IN < 2 || NUM_IN > MUX_MAX_IN) begin : g_bad_num_in
        $error("mux_pipe_n: NUM_IN out of supported range");
    end

    logic             in_range;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH:0]   beat;
    logic             in_ready;
    logic             accept;
    logic             retire;
    logic             out_valid;
    logic             out_load;
    logic [WIDTH:0]   out_din;
    logic [WIDTH:0]   out_beat;

    // Unmatched selects fall through to zero data.
    always_comb begin
        in_range = sel_in_range(32'(bus.in_sel), NUM_IN);
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                sel_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign beat   = {~in_range, sel_data};
    assign accept = bus.in_valid & in_ready;
    assign retire = out_valid & bus.out_ready;

`ifdef MUX_SKID_EN
    logic           skid_valid;
    logic [WIDTH:0] skid_beat;

    assign in_ready = ~skid_valid;
    // Skid drains ahead of any new beat to keep ordering.
    assign out_load = (~out_valid | retire) & (skid_valid | accept);
    assign out_din  = skid_valid ? skid_beat : beat;

    mux_pipe_stage #(
        .DW(WIDTH + 1)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush_i(flush),
        .load_i (accept & out_valid & ~bus.out_ready),
        .clr_i  (retire),
        .data_i (beat),
        .valid_o(skid_valid),
        .data_o (skid_beat)
    );
`else
    assign in_ready = bus.out_ready | ~out_valid;
    assign out_load = accept;
    assign out_din  = beat;
`endif

    mux_pipe_stage #(
        .DW(WIDTH + 1)
    ) u_out (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush_i(flush),
        .load_i (out_load),
        .clr_i  (retire),
        .data_i (out_din),
        .valid_o(out_valid),
        .data_o (out_beat)
    );

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_beat[WIDTH-1:0];
    assign bus.out_sel_err = out_beat[WIDTH];

    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_cnt_d;

    // Counts on the input handshake, so beats dropped by flush still register.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && !in_range && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed self-checking bench for mux_pipe_n; valid with or without MUX_SKID_EN.
module tb_mux_pipe_n;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_IN = 3;
    localparam int unsigned ERR_W  = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [ERR_W-1:0] err_count;

    int checks   = 0;
    int failures = 0;

    mux_pipe_n_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

    mux_pipe_n #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN),
        .ERR_W (ERR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] pack3(input logic [31:0] a, b, c);
        return {c, b, a};
    endfunction

    // Stream beat i selects input i%3; input k carries (k+1)<<28 | i.
    function automatic logic [31:0] stream_val(input int i);
        return (32'(i % 3 + 1) << 28) | 32'(i);
    endfunction

    initial begin
        int sent;
        int got;
        bit stalled;

        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_sel_err", bus.out_sel_err, 0);
        check("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);

        // Basic in-range select, latency 1
        @(negedge clk);
        bus.in_data   = pack3(32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222);
        bus.in_sel    = 2'd1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_out_data", bus.out_data, 32'hDEAD_BEEF);
        check("t1_sel_err", bus.out_sel_err, 0);
        check("t1_err_count", err_count, 0);

        // Out-of-range select and counter saturation
        bus.in_data  = pack3(32'hAAAA_0000, 32'hBBBB_0000, 32'hCCCC_0000);
        bus.in_sel   = 2'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        #1;
        check("t2_out_valid", bus.out_valid, 1);
        check("t2_out_data", bus.out_data, 0);
        check("t2_sel_err", bus.out_sel_err, 1);
        check("t2_err_count1", err_count, 1);
        @(negedge clk);
        #1;
        check("t2_err_count2", err_count, 2);
        @(negedge clk);
        #1;
        check("t2_err_count3", err_count, 3);
        @(negedge clk);
        #1;
        check("t2_err_count4", err_count, 3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("t2_err_count5", err_count, 3);
        check("t2_sel_err_last", bus.out_sel_err, 1);

        // Streaming under toggling backpressure
        sent    = 0;
        got     = 0;
        stalled = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc % 2 == 0);
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.in_sel   = 2'(sent % 3);
                bus.in_data  = pack3(32'h1000_0000 | 32'(sent), 32'h2000_0000 | 32'(sent),
                                     32'h3000_0000 | 32'(sent));
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (stalled) check("t3_hold_valid", bus.out_valid, 1);
            if (bus.out_valid) begin
                check("t3_data", bus.out_data, stream_val(got));
                check("t3_sel_err", bus.out_sel_err, 0);
                if (bus.out_ready) got++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            if (bus.in_valid && bus.in_ready) sent++;
        end
        bus.in_valid = 1'b0;
        check("t3_sent", sent, 8);
        check("t3_received", got, 8);

        // Flush of a held beat
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = pack3(32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("t4_held_valid", bus.out_valid, 1);
        check("t4_held_data", bus.out_data, 32'hCAFE_0001);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("t4_flush_valid", bus.out_valid, 0);
        check("t4_flush_in_ready", bus.in_ready, 1);
        check("t4_err_kept", err_count, 3);

        // Asynchronous reset mid-stall
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = pack3(32'h0, 32'h0, 32'h5A5A_5A5A);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("t5_stall_valid", bus.out_valid, 1);
        check("t5_stall_data", bus.out_data, 32'h5A5A_5A5A);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", bus.out_valid, 0);
        check("t5_async_data", bus.out_data, 0);
        check("t5_async_err", err_count, 0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("t5_post_in_ready", bus.in_ready, 1);
        check("t5_post_valid", bus.out_valid, 0);

        // Back-to-back throughput
        for (int j = 0; j <= 16; j++) begin
            @(negedge clk);
            if (j < 16) begin
                bus.in_valid = 1'b1;
                bus.in_sel   = 2'd2;
                bus.in_data  = pack3(32'h0, 32'h0, 32'h6000_0000 | 32'(j));
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (j > 0) begin
                check("t6_valid", bus.out_valid, 1);
                check("t6_data", bus.out_data, 32'h6000_0000 | 32'(j - 1));
            end
            if (j < 16) check("t6_in_ready", bus.in_ready, 1);
        end
        check("t6_err_count", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
